hazard_scoreboard: RTL and testbench

//  Producer side of the EX/MEM and MEM/WB bypass interface. Keeps a shadow

---
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: shadows EX/MEM/WB destination info for the
// forwarding unit, detects load-use hazards, and handles freezes and flushes.
module hazard_scoreboard #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memAccess,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              stall,
    output logic              bubble,
    output logic              freeze,
    output logic [REG_AW-1:0] EXMEMrd,
    output logic              EXMEMregWrite,
    output logic [REG_AW-1:0] MEMWBrd,
    output logic              MEMWBregWrite,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  freeze_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memaccess;
    } stage_t;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_LOADUSE,
        ACT_FLUSH,
        ACT_FREEZE
    } act_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_t ex_q, mem_q, wb_q;
    stage_t id_s;
    act_t   act;
    logic   freeze_cond;
    logic   loaduse;
    logic   rs1_hit, rs2_hit;

    always_comb begin
        id_s = {id_valid, id_rd, id_regWrite, id_memRead, id_memAccess};

        freeze_cond = mem_q.valid && mem_q.memaccess && !mem_ready;
        rs1_hit     = id_use_rs1 && (id_rs1 == ex_q.rd);
        rs2_hit     = id_use_rs2 && (id_rs2 == ex_q.rd);
        loaduse     = id_valid && ex_q.valid && ex_q.memread &&
                      (ex_q.rd != '0) && (rs1_hit || rs2_hit);

        act = ACT_ADVANCE;
        if (freeze_cond)
            act = ACT_FREEZE;
        else if (flush)
            act = ACT_FLUSH;
        else if (loaduse)
            act = ACT_LOADUSE;

        // Stages are being cleared during reset, so no hold/bubble request is meaningful.
        stall  = !reset && ((act == ACT_FREEZE) || (act == ACT_LOADUSE));
        bubble = !reset && ((act == ACT_FLUSH)  || (act == ACT_LOADUSE));
        freeze = !reset && (act == ACT_FREEZE);

        EXMEMrd       = mem_q.rd;
        EXMEMregWrite = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);
        MEMWBrd       = wb_q.rd;
        MEMWBregWrite = wb_q.valid && wb_q.regwrite && (wb_q.rd != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            case (act)
                ACT_FREEZE: begin
                    if (freeze_cnt != '1)
                        freeze_cnt <= freeze_cnt + CNT_ONE;
                end
                ACT_FLUSH, ACT_LOADUSE: begin
                    ex_q  <= '0;
                    mem_q <= ex_q;
                    wb_q  <= mem_q;
                    if ((act == ACT_LOADUSE) && (stall_cnt != '1))
                        stall_cnt <= stall_cnt + CNT_ONE;
                end
                default: begin
                    ex_q  <= id_s;
                    mem_q <= ex_q;
                    wb_q  <= mem_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written freeze and
// reset sequences, then random traffic against an instruction-level model.
module tb_hazard_scoreboard;

    localparam int unsigned AW     = 5;
    localparam int unsigned CW     = 4;
    localparam int          CNTMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          id_regWrite, id_memRead, id_memAccess;
    logic          flush, mem_ready;
    logic          stall, bubble, freeze;
    logic [AW-1:0] EXMEMrd, MEMWBrd;
    logic          EXMEMregWrite, MEMWBregWrite;
    logic [CW-1:0] stall_cnt, freeze_cnt;

    hazard_scoreboard #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memAccess(id_memAccess), .flush(flush), .mem_ready(mem_ready),
        .stall(stall), .bubble(bubble), .freeze(freeze),
        .EXMEMrd(EXMEMrd), .EXMEMregWrite(EXMEMregWrite),
        .MEMWBrd(MEMWBrd), .MEMWBregWrite(MEMWBregWrite),
        .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          ma;
    } instr_t;

    typedef struct {
        instr_t        id;
        logic          fl;
        logic          rdy;
        logic          e_stall;
        logic          e_bubble;
        logic          e_freeze;
        logic [AW-1:0] e_exrd;
        logic          e_exrw;
        logic [AW-1:0] e_wbrd;
        logic          e_wbrw;
        int            e_scnt;
        int            e_fcnt;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic instr_t mk_nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t mk_lw(input logic [AW-1:0] rd, input logic [AW-1:0] rs1);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.u1 = 1'b1;
        i.rw = 1'b1; i.mr = 1'b1; i.ma = 1'b1;
        return i;
    endfunction

    function automatic instr_t mk_alu(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                                      input logic [AW-1:0] rs2);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic vec_t mkv(input instr_t id, input logic fl, input logic rdy,
                                 input logic st, input logic bu, input logic fz,
                                 input logic [AW-1:0] exrd, input logic exrw,
                                 input logic [AW-1:0] wbrd, input logic wbrw,
                                 input int scnt, input int fcnt);
        vec_t v;
        v.id = id; v.fl = fl; v.rdy = rdy;
        v.e_stall = st; v.e_bubble = bu; v.e_freeze = fz;
        v.e_exrd = exrd; v.e_exrw = exrw; v.e_wbrd = wbrd; v.e_wbrw = wbrw;
        v.e_scnt = scnt; v.e_fcnt = fcnt;
        return v;
    endfunction

    task automatic drive(input instr_t i);
        id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_use_rs1 = i.u1; id_use_rs2 = i.u2; id_rd = i.rd;
        id_regWrite = i.rw; id_memRead = i.mr; id_memAccess = i.ma;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; mem_ready = 1'b1;
        drive(mk_nop());
        step();
        reset = 1'b0;
    endtask

    // Instruction-level model: slot 0 = EX, 1 = MEM, 2 = WB.
    instr_t pipe [3];
    int     m_scnt, m_fcnt;

    function automatic logic eff_rw(input instr_t s);
        return s.v && s.rw && (s.rd != '0);
    endfunction

    function automatic logic m_freeze();
        return pipe[1].v && pipe[1].ma && !mem_ready;
    endfunction

    function automatic logic m_loaduse();
        instr_t ld;
        ld = pipe[0];
        if (!(id_valid && ld.v && ld.mr) || ld.rd == '0)
            return 1'b0;
        return (id_use_rs1 && id_rs1 == ld.rd) || (id_use_rs2 && id_rs2 == ld.rd);
    endfunction

    task automatic model_edge();
        instr_t cur;
        logic   fz, lu;
        cur = {id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regWrite, id_memRead, id_memAccess};
        fz = m_freeze();
        lu = m_loaduse();
        if (reset) begin
            foreach (pipe[k]) pipe[k] = '0;
            m_scnt = 0;
            m_fcnt = 0;
        end else if (fz) begin
            if (m_fcnt < CNTMAX) m_fcnt++;
        end else begin
            for (int k = 2; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = (flush || lu) ? '0 : cur;
            if (!flush && lu && m_scnt < CNTMAX) m_scnt++;
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        i = '0;
        i.v   = ($urandom_range(4) != 0);
        i.rd  = AW'($urandom_range(3));
        i.rs1 = AW'($urandom_range(3));
        i.rs2 = AW'($urandom_range(3));
        i.u1  = ($urandom_range(7) != 0);
        i.u2  = 1'($urandom_range(1));
        kind  = int'($urandom_range(3));
        case (kind)
            0: begin i.rw = 1'b1; i.mr = 1'b1; i.ma = 1'b1; end
            1: i.ma = 1'b1;
            2: i.rw = 1'b1;
            default: ;
        endcase
        return i;
    endfunction

    vec_t vecs[$];

    initial begin
        reset = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        drive(mk_nop());

        // Directed table, applied from a fresh reset.
        vecs.push_back(mkv(mk_lw(5, 1),     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(mk_alu(6, 5, 7), 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(mk_alu(6, 5, 7), 0, 1, 0, 0, 0, 5, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_nop(),        0, 1, 0, 0, 0, 0, 0, 5, 1, 1, 0));
        vecs.push_back(mkv(mk_nop(),        0, 1, 0, 0, 0, 6, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_lw(0, 1),     0, 1, 0, 0, 0, 0, 0, 6, 1, 1, 0));
        vecs.push_back(mkv(mk_alu(6, 0, 1), 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_nop(),        0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_lw(5, 1),     0, 1, 0, 0, 0, 6, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_alu(6, 5, 7), 1, 1, 0, 1, 0, 0, 0, 6, 1, 1, 0));
        vecs.push_back(mkv(mk_nop(),        0, 1, 0, 0, 0, 5, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_alu(1, 0, 0), 0, 1, 0, 0, 0, 0, 0, 5, 1, 1, 0));
        vecs.push_back(mkv(mk_alu(2, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_alu(3, 0, 0), 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(mk_nop(),        0, 1, 0, 0, 0, 2, 1, 1, 1, 1, 0));
        vecs.push_back(mkv(mk_nop(),        0, 1, 0, 0, 0, 3, 1, 2, 1, 1, 0));
        vecs.push_back(mkv(mk_nop(),        0, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0));

        do_reset();
        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].id);
            flush = vecs[n].fl;
            mem_ready = vecs[n].rdy;
            #3;
            chk($sformatf("vec%0d.stall", n),  32'(stall),  32'(vecs[n].e_stall));
            chk($sformatf("vec%0d.bubble", n), 32'(bubble), 32'(vecs[n].e_bubble));
            chk($sformatf("vec%0d.freeze", n), 32'(freeze), 32'(vecs[n].e_freeze));
            chk($sformatf("vec%0d.exmem_rw", n), 32'(EXMEMregWrite), 32'(vecs[n].e_exrw));
            chk($sformatf("vec%0d.memwb_rw", n), 32'(MEMWBregWrite), 32'(vecs[n].e_wbrw));
            if (vecs[n].e_exrw)
                chk($sformatf("vec%0d.exmem_rd", n), 32'(EXMEMrd), 32'(vecs[n].e_exrd));
            if (vecs[n].e_wbrw)
                chk($sformatf("vec%0d.memwb_rd", n), 32'(MEMWBrd), 32'(vecs[n].e_wbrd));
            chk($sformatf("vec%0d.stall_cnt", n),  32'(stall_cnt),  32'(vecs[n].e_scnt));
            chk($sformatf("vec%0d.freeze_cnt", n), 32'(freeze_cnt), 32'(vecs[n].e_fcnt));
            step();
        end
        flush = 1'b0;

        // Load waits three cycles in MEM; everything holds, then drains.
        do_reset();
        drive(mk_lw(9, 1)); step();
        drive(mk_nop());    step();
        drive(mk_alu(4, 9, 0));
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b0;
            #3;
            chk($sformatf("frz%0d.freeze", c), 32'(freeze), 1);
            chk($sformatf("frz%0d.stall", c),  32'(stall),  1);
            chk($sformatf("frz%0d.bubble", c), 32'(bubble), 0);
            chk($sformatf("frz%0d.exmem_rd", c), 32'(EXMEMrd), 9);
            chk($sformatf("frz%0d.exmem_rw", c), 32'(EXMEMregWrite), 1);
            chk($sformatf("frz%0d.freeze_cnt", c), 32'(freeze_cnt), 32'(c));
            step();
        end
        mem_ready = 1'b1;
        #3;
        chk("frz_end.freeze", 32'(freeze), 0);
        chk("frz_end.stall",  32'(stall),  0);
        chk("frz_end.freeze_cnt", 32'(freeze_cnt), 3);
        chk("frz_end.stall_cnt",  32'(stall_cnt),  0);
        step();
        drive(mk_nop());
        #3;
        chk("frz_drain.memwb_rd", 32'(MEMWBrd), 9);
        chk("frz_drain.memwb_rw", 32'(MEMWBregWrite), 1);
        step();

        // Reset while a load-use stall has been counted and a freeze is active.
        do_reset();
        drive(mk_lw(9, 1));     step();
        drive(mk_alu(6, 9, 7)); step();
        mem_ready = 1'b0;
        #3;
        chk("rstfrz.freeze_before", 32'(freeze), 1);
        chk("rstfrz.stall_cnt_before", 32'(stall_cnt), 1);
        step();
        chk("rstfrz.freeze_cnt_before", 32'(freeze_cnt), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #3;
        chk("rstfrz.freeze", 32'(freeze), 0);
        chk("rstfrz.stall",  32'(stall),  0);
        chk("rstfrz.bubble", 32'(bubble), 0);
        chk("rstfrz.exmem_rw", 32'(EXMEMregWrite), 0);
        chk("rstfrz.memwb_rw", 32'(MEMWBregWrite), 0);
        chk("rstfrz.stall_cnt",  32'(stall_cnt),  0);
        chk("rstfrz.freeze_cnt", 32'(freeze_cnt), 0);
        step();
        mem_ready = 1'b1;

        // Random traffic against the model.
        do_reset();
        foreach (pipe[k]) pipe[k] = '0;
        m_scnt = 0;
        m_fcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            drive(rand_instr());
            flush     = ($urandom_range(9) == 0);
            mem_ready = ($urandom_range(3) != 0);
            reset     = ($urandom_range(63) == 0);
            #3;
            if (!reset) begin
                chk("rnd.freeze", 32'(freeze), 32'(m_freeze()));
                chk("rnd.stall",  32'(stall),  32'(m_freeze() || (!flush && m_loaduse())));
                chk("rnd.bubble", 32'(bubble), 32'(!m_freeze() && (flush || m_loaduse())));
            end
            chk("rnd.exmem_rw", 32'(EXMEMregWrite), 32'(eff_rw(pipe[1])));
            chk("rnd.memwb_rw", 32'(MEMWBregWrite), 32'(eff_rw(pipe[2])));
            if (eff_rw(pipe[1])) chk("rnd.exmem_rd", 32'(EXMEMrd), 32'(pipe[1].rd));
            if (eff_rw(pipe[2])) chk("rnd.memwb_rd", 32'(MEMWBrd), 32'(pipe[2].rd));
            chk("rnd.stall_cnt",  32'(stall_cnt),  32'(m_scnt));
            chk("rnd.freeze_cnt", 32'(freeze_cnt), 32'(m_fcnt));
            @(posedge clk);
            model_edge();
            #1;
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
